// File: rtl/bc_pkg.sv
// Shared definitions for the basic-computer accumulator stage: data width,
// ALU function encodings, controller signal indices and an op-decode helper.
// Optional feature macro: BC_ALU_XOR_EN (enables the XOR function on alu_op 110).
package bc_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_ADD = 3'b001,
        ALU_LDA = 3'b010,
        ALU_CMA = 3'b011,
        ALU_CIL = 3'b100,
        ALU_CIR = 3'b101,
        ALU_XOR = 3'b110,
        ALU_NOP = 3'b111
    } aluOp_t;

    // Positions of this stage's strobes in the controller's control word.
    localparam int SIG_LD     = 9;
    localparam int SIG_INR    = 10;
    localparam int SIG_CLR    = 11;
    localparam int SIG_E_CMP  = 18;
    localparam int SIG_E_CLR  = 19;
    localparam int SIG_ALU_OP = 20;

    // True when an ld with this function actually writes AC; NOP never does,
    // and XOR only does when the XOR function is built in.
    function automatic logic aluOpWrites(input aluOp_t op);
`ifdef BC_ALU_XOR_EN
        return (op != ALU_NOP);
`else
        return (op != ALU_NOP) && (op != ALU_XOR);
`endif
    endfunction

endpackage

// File: rtl/bc_alu.sv
// Combinational ALU of the accumulator stage: logic, add, load, complement
// and circulate-through-E functions on AC and DR.
// Optional feature macro: BC_ALU_XOR_EN (alu_op 110 computes AC ^ DR).
module bc_alu
    import bc_pkg::*;
#(
    parameter int WIDTH = bc_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] ac,
    input  logic [WIDTH-1:0] dr,
    input  logic             e,
    input  aluOp_t           alu_op,
    output logic [WIDTH-1:0] result,
    output logic             e_next,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, ac} + {1'b0, dr};

    // Select the function result; E only changes for ADD and the circulates.
    always_comb begin
        result = ac;
        e_next = e;
        carry  = 1'b0;
        ovf    = 1'b0;
        unique case (alu_op)
            ALU_AND: result = ac & dr;
            ALU_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                e_next = sum[WIDTH];
                ovf    = (ac[WIDTH-1] == dr[WIDTH-1]) &&
                         (sum[WIDTH-1] != ac[WIDTH-1]);
            end
            ALU_LDA: result = dr;
            ALU_CMA: result = ~ac;
            ALU_CIL: begin
                result = {ac[WIDTH-2:0], e};
                e_next = ac[WIDTH-1];
            end
            ALU_CIR: begin
                result = {e, ac[WIDTH-1:1]};
                e_next = ac[0];
            end
`ifdef BC_ALU_XOR_EN
            ALU_XOR: result = ac ^ dr;
`else
            ALU_XOR: result = ac;
`endif
            ALU_NOP: result = ac;
            default: result = ac;
        endcase
    end

endmodule

// File: rtl/bc_acc_unit.sv
// Accumulator stage of the basic computer: holds AC and E, applies the
// controller's strobes with clr > ld > inr priority on AC and
// e_clr > e_cmp > ALU side effect on E, and registers CO/Z/N/OVF.
// Optional feature macro: BC_ALU_XOR_EN (see bc_alu).
module bc_acc_unit #(
    parameter int WIDTH = bc_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dr_data,
    input  logic [WIDTH-1:0] bus_data,
    input  logic             ld,
    input  logic             inr,
    input  logic             clr,
    input  logic             e_cmp,
    input  logic             e_clr,
    input  logic [2:0]       alu_op,
    output logic [WIDTH-1:0] ac,
    output logic             e,
    output logic             co,
    output logic             z,
    output logic             n,
    output logic             ovf
);

    import bc_pkg::*;

    logic [WIDTH-1:0] ac_q, ac_d;
    logic             e_q, e_d;
    logic             co_q, co_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             ovf_q, ovf_d;

    aluOp_t           aluOp;
    logic [WIDTH-1:0] aluResult;
    logic             aluENext;
    logic             aluCarry;
    logic             aluOvf;
    logic [WIDTH:0]   incSum;
    logic             acWrite;
    logic             aluEffect;

    // Input-register loads will use the bus later; it is not consumed yet.
    logic             unusedBus;
    assign unusedBus = ^bus_data;

    assign aluOp  = aluOp_t'(alu_op);
    assign incSum = {1'b0, ac_q} + {{WIDTH{1'b0}}, 1'b1};

    bc_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .ac     (ac_q),
        .dr     (dr_data),
        .e      (e_q),
        .alu_op (aluOp),
        .result (aluResult),
        .e_next (aluENext),
        .carry  (aluCarry),
        .ovf    (aluOvf)
    );

    // Next-state selection: one AC writer wins, flags follow the new AC.
    always_comb begin
        ac_d      = ac_q;
        e_d       = e_q;
        co_d      = co_q;
        z_d       = z_q;
        n_d       = n_q;
        ovf_d     = ovf_q;
        acWrite   = 1'b0;
        aluEffect = 1'b0;

        if (clr) begin
            ac_d    = '0;
            co_d    = 1'b0;
            ovf_d   = 1'b0;
            acWrite = 1'b1;
        end else if (ld) begin
            if (aluOpWrites(aluOp)) begin
                ac_d      = aluResult;
                co_d      = aluCarry;
                ovf_d     = aluOvf;
                acWrite   = 1'b1;
                aluEffect = 1'b1;
            end
        end else if (inr) begin
            ac_d    = incSum[WIDTH-1:0];
            co_d    = incSum[WIDTH];
            ovf_d   = ~ac_q[WIDTH-1] & incSum[WIDTH-1];
            acWrite = 1'b1;
        end

        if (acWrite) begin
            z_d = (ac_d == '0);
            n_d = ac_d[WIDTH-1];
        end

        if (e_clr) begin
            e_d = 1'b0;
        end else if (e_cmp) begin
            e_d = ~e_q;
        end else if (aluEffect) begin
            e_d = aluENext;
        end
    end

    // State registers; reset leaves AC zero so Z starts set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_q  <= '0;
            e_q   <= 1'b0;
            co_q  <= 1'b0;
            z_q   <= 1'b1;
            n_q   <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            ac_q  <= ac_d;
            e_q   <= e_d;
            co_q  <= co_d;
            z_q   <= z_d;
            n_q   <= n_d;
            ovf_q <= ovf_d;
        end
    end

    assign ac  = ac_q;
    assign e   = e_q;
    assign co  = co_q;
    assign z   = z_q;
    assign n   = n_q;
    assign ovf = ovf_q;

endmodule
